// File: rtl/l2_fill_arbiter.sv
// l2_fill_arbiter: round-robin sharing of one L2 line-fill port between I-cache and D-cache misses
module l2_fill_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 256,
  parameter int OFFSET_BITS = 5,
  parameter int TIMEOUT     = 63
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_gnt_o,
  output logic              ic_valid_o,
  output logic [LINE_W-1:0] ic_data_o,
  input  logic              dc_req_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  output logic              dc_gnt_o,
  output logic              dc_valid_o,
  output logic [LINE_W-1:0] dc_data_o,
  output logic              l2_re_o,
  output logic [ADDR_W-1:0] l2_addr_o,
  input  logic              l2_ready_i,
  input  logic [LINE_W-1:0] l2_data_i,
  output logic              busy_o,
  output logic              timeout_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] ALIGN = {ADDR_W{1'b1}} << OFFSET_BITS;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t            state_q, state_d;
  logic              owner_q, owner_d, rr_last_q, rr_last_d, reissue_q, reissue_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [LINE_W-1:0] ic_data_q, ic_data_d, dc_data_q, dc_data_d;
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    reissue_d = reissue_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    ic_data_d = ic_data_q;
    dc_data_d = dc_data_q;
    case (state_q)
      IDLE: if (ic_req_i || dc_req_i) begin
        owner_d   = (ic_req_i && dc_req_i) ? ~rr_last_q : dc_req_i;
        addr_d    = owner_d ? dc_addr_i : ic_addr_i;
        reissue_d = 1'b0;
        state_d   = ISSUE;
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (l2_ready_i) begin
          ic_data_d = owner_q ? ic_data_q : l2_data_i;
          dc_data_d = owner_q ? l2_data_i : dc_data_q;
          state_d   = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          reissue_d = 1'b1;
          state_d   = ISSUE;
        end
      end
      default: begin
        rr_last_d = owner_q;
        state_d   = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      reissue_q <= 1'b0;
      addr_q    <= '0;
      cnt_q     <= '0;
      ic_data_q <= '0;
      dc_data_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      reissue_q <= reissue_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      ic_data_q <= ic_data_d;
      dc_data_q <= dc_data_d;
    end
  end
  // grant only on the first issue of a miss; a re-issue is flagged as a timeout instead
  assign l2_re_o    = state_q == ISSUE;
  assign l2_addr_o  = l2_re_o ? (addr_q & ALIGN) : '0;
  assign ic_gnt_o   = l2_re_o && !reissue_q && !owner_q;
  assign dc_gnt_o   = l2_re_o && !reissue_q && owner_q;
  assign timeout_o  = l2_re_o && reissue_q;
  assign ic_valid_o = state_q == RESP && !owner_q;
  assign dc_valid_o = state_q == RESP && owner_q;
  assign busy_o     = state_q != IDLE;
  assign ic_data_o  = ic_data_q;
  assign dc_data_o  = dc_data_q;
endmodule

// File: tb/tb_l2_fill_arbiter.sv
// tb_l2_fill_arbiter: directed table, hand sequences and random transactions against a timeline model
module tb_l2_fill_arbiter;
  localparam int T = 8;
  logic clk = 1'b0, reset = 1'b0;
  logic ic_req_i = 1'b0, dc_req_i = 1'b0, l2_ready_i = 1'b0;
  logic [31:0] ic_addr_i = '0, dc_addr_i = '0;
  logic [255:0] l2_data_i = '0;
  logic ic_gnt_o, ic_valid_o, dc_gnt_o, dc_valid_o, l2_re_o, busy_o, timeout_o;
  logic [31:0] l2_addr_o;
  logic [255:0] ic_data_o, dc_data_o;
  int total = 0, bad = 0;
  logic [255:0] ic_m = '0, dc_m = '0;
  bit rr_m = 1'b1;
  l2_fill_arbiter #(.ADDR_W(32), .LINE_W(256), .OFFSET_BITS(5), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_gnt_o(ic_gnt_o), .ic_valid_o(ic_valid_o), .ic_data_o(ic_data_o),
    .dc_req_i(dc_req_i), .dc_addr_i(dc_addr_i), .dc_gnt_o(dc_gnt_o), .dc_valid_o(dc_valid_o), .dc_data_o(dc_data_o),
    .l2_re_o(l2_re_o), .l2_addr_o(l2_addr_o), .l2_ready_i(l2_ready_i), .l2_data_i(l2_data_i),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit ic, dc;
    logic [31:0] ia, da;
    int r, w;
    bit sp, eo;
    logic [31:0] ea;
  } vec_t;
  vec_t tbl[6];
  function automatic void chk(string n, logic [255:0] a, logic [255:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endfunction
  function automatic logic [255:0] rnd_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction
  task automatic check_all(input bit b, input bit re, input logic [31:0] a, input bit to,
                           input bit ig, input bit dg, input bit iv, input bit dv);
    chk("busy", busy_o, b);
    chk("l2_re", l2_re_o, re);
    chk("l2_addr", l2_addr_o, a);
    chk("timeout", timeout_o, to);
    chk("ic_gnt", ic_gnt_o, ig);
    chk("dc_gnt", dc_gnt_o, dg);
    chk("ic_valid", ic_valid_o, iv);
    chk("dc_valid", dc_valid_o, dv);
    chk("ic_data", ic_data_o, ic_m);
    chk("dc_data", dc_data_o, dc_m);
  endtask
  // t=0 is the IDLE sampling cycle; issues at 1+j*(T+1); ready lands w WAIT cycles after the last issue
  task automatic run_txn(input bit ic, input bit dc, input logic [31:0] ia, input logic [31:0] da,
                         input int r, input int w, input bit sp, input bit hold,
                         input bit eo, input logic [31:0] ea);
    int tr;
    bit iss;
    logic [255:0] cap;
    tr = 1 + r * (T + 1) + w;
    cap = '0;
    for (int t = 0; t <= tr + 1; t++) begin
      @(negedge clk);
      iss = (t == 1) || (t > 1 && t < tr && (t - 1) % (T + 1) == 0);
      if (t == 0) begin
        ic_req_i = ic; dc_req_i = dc; ic_addr_i = ia; dc_addr_i = da;
      end else if (!hold) begin
        ic_req_i = 1'($urandom); dc_req_i = 1'($urandom);
      end
      l2_data_i = rnd_line();
      l2_ready_i = (t == tr) || (sp && (t == 0 || iss || t == tr + 1));
      if (t == tr) cap = l2_data_i;
      if (t == tr + 1) begin
        if (eo) dc_m = cap; else ic_m = cap;
      end
      check_all(t >= 1, iss, iss ? ea : 32'h0, iss && t > 1, t == 1 && !eo, t == 1 && eo,
                t == tr + 1 && !eo, t == tr + 1 && eo);
    end
    rr_m = eo;
  endtask
  initial begin
    bit ic, dc, eo;
    int p;
    logic [31:0] ia, da;
    tbl[0] = '{ic:1, dc:0, ia:32'h1000_0014, da:32'h0,         r:0, w:2, sp:0, eo:0, ea:32'h1000_0000};
    tbl[1] = '{ic:1, dc:1, ia:32'h1234_5678, da:32'h2000_003F, r:0, w:1, sp:0, eo:1, ea:32'h2000_0020};
    tbl[2] = '{ic:1, dc:1, ia:32'hFFFF_FFFF, da:32'h0000_0001, r:0, w:4, sp:1, eo:0, ea:32'hFFFF_FFE0};
    tbl[3] = '{ic:0, dc:1, ia:32'h0,         da:32'h8000_1234, r:2, w:3, sp:0, eo:1, ea:32'h8000_1220};
    tbl[4] = '{ic:1, dc:0, ia:32'h0000_003F, da:32'h0,         r:0, w:T, sp:1, eo:0, ea:32'h0000_0020};
    tbl[5] = '{ic:1, dc:1, ia:32'hABCD_0040, da:32'h5555_5555, r:1, w:T, sp:1, eo:1, ea:32'h5555_5540};
    repeat (3) @(negedge clk);
    check_all(0, 0, 32'h0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++)
      run_txn(1, 1, 32'h0000_1000 + 32'(i), 32'h0000_2000 + 32'(i), 0, 2, 0, 1,
              i[0], i[0] ? 32'h0000_2000 : 32'h0000_1000);
    for (int i = 0; i < 6; i++)
      run_txn(tbl[i].ic, tbl[i].dc, tbl[i].ia, tbl[i].da, tbl[i].r, tbl[i].w, tbl[i].sp, 0,
              tbl[i].eo, tbl[i].ea);
    @(negedge clk);
    ic_req_i = 1'b1; dc_req_i = 1'b0; ic_addr_i = 32'h0BAD_F00D; l2_ready_i = 1'b0;
    check_all(0, 0, 32'h0, 0, 0, 0, 0, 0);
    @(negedge clk);
    ic_req_i = 1'b0;
    check_all(1, 1, 32'h0BAD_F000, 0, 1, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    check_all(1, 0, 32'h0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    ic_m = '0; dc_m = '0; rr_m = 1'b1;
    check_all(0, 0, 32'h0, 0, 0, 0, 0, 0);
    @(negedge clk);
    l2_ready_i = 1'b1;
    check_all(0, 0, 32'h0, 0, 0, 0, 0, 0);
    repeat (2) begin
      @(negedge clk);
      l2_ready_i = 1'b0;
      check_all(0, 0, 32'h0, 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 150; i++) begin
      p = $urandom_range(1, 3);
      ic = p[0]; dc = p[1];
      ia = $urandom; da = $urandom;
      eo = (ic && dc) ? !rr_m : dc;
      run_txn(ic, dc, ia, da, $urandom_range(0, 2), $urandom_range(1, T), 1'($urandom), 0,
              eo, (eo ? da : ia) & 32'hFFFF_FFE0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
